regfile_2r1w: RTL and testbench

- Parametrised register file: DEPTH words of WIDTH bits, one synchronous write port, two independent read ports (A, B).
- Read ports are registered and enable-gated. Each output holds its last value when its port is not enabled.
- Write-to-read bypass gives same-cycle write data to a read of the same address.
- Storage building block for datapath exercises: ALU operand fetch and accumulator banks.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_word.sv | 26 ++
 rtl/regfile_2r1w.sv | 108 ++++++++++
 tb/tb_regfile_2r1w.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the 2-read/1-write register file.
package regfile_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH = 8;
    localparam int unsigned ZERO_WORD     = 0;

    function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/regfile_word.sv
// One WIDTH-bit storage word with asynchronous active-low clear and load enable.
module regfile_word
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/regfile_2r1w.sv
// Register file: DEPTH x WIDTH, one write port, two registered enable-gated read ports.
// Optional REGFILE_ZERO_REG_EN hardwires word 0 to zero (no storage, no bypass).
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re_a,
    input  logic [AW-1:0]    raddr_a,
    input  logic             re_b,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    output logic             rvalid_a,
    output logic             rvalid_b
);

    logic [WIDTH-1:0] w_mem [DEPTH];
    logic             w_wr_ok;
    logic             w_byp_a;
    logic             w_byp_b;
    logic [WIDTH-1:0] w_rd_a;
    logic [WIDTH-1:0] w_rd_b;
    logic [WIDTH-1:0] r_rdata_a;
    logic [WIDTH-1:0] r_rdata_b;
    logic             r_rvalid_a;
    logic             r_rvalid_b;

    // A write that will actually land in storage; also the only legal bypass source.
    always_comb begin
        w_wr_ok = we && addr_in_range(32'(waddr), DEPTH);
`ifdef REGFILE_ZERO_REG_EN
        if (32'(waddr) == ZERO_WORD) begin
            w_wr_ok = 1'b0;
        end
`endif
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
`ifdef REGFILE_ZERO_REG_EN
        if (i == ZERO_WORD) begin : g_zero
            assign w_mem[i] = '0;
        end else begin : g_store
            logic w_load;
            assign w_load = w_wr_ok && (32'(waddr) == i);
            regfile_word #(.WIDTH(WIDTH)) u_word (
                .clk    (clk),
                .rst_n  (rst_n),
                .i_load (w_load),
                .i_d    (wdata),
                .o_q    (w_mem[i])
            );
        end
`else
        logic w_load;
        assign w_load = w_wr_ok && (32'(waddr) == i);
        regfile_word #(.WIDTH(WIDTH)) u_word (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_load (w_load),
            .i_d    (wdata),
            .o_q    (w_mem[i])
        );
`endif
    end

    assign w_byp_a = w_wr_ok && re_a && (raddr_a == waddr);
    assign w_byp_b = w_wr_ok && re_b && (raddr_b == waddr);

    // Out-of-range addresses match no word and fall through to zero.
    always_comb begin
        w_rd_a = '0;
        w_rd_b = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (32'(raddr_a) == i) w_rd_a = w_mem[i];
            if (32'(raddr_b) == i) w_rd_b = w_mem[i];
        end
        if (w_byp_a) w_rd_a = wdata;
        if (w_byp_b) w_rd_b = wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata_a  <= '0;
            r_rdata_b  <= '0;
            r_rvalid_a <= 1'b0;
            r_rvalid_b <= 1'b0;
        end else begin
            r_rvalid_a <= re_a;
            r_rvalid_b <= re_b;
            if (re_a) r_rdata_a <= w_rd_a;
            if (re_b) r_rdata_b <= w_rd_b;
        end
    end

    assign rdata_a  = r_rdata_a;
    assign rdata_b  = r_rdata_b;
    assign rvalid_a = r_rvalid_a;
    assign rvalid_b = r_rvalid_b;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed self-checking bench for regfile_2r1w (DEPTH=6 to exercise out-of-range addresses).
module tb_regfile_2r1w;

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       we;
    logic [2:0] waddr;
    logic [7:0] wdata;
    logic       re_a;
    logic [2:0] raddr_a;
    logic       re_b;
    logic [2:0] raddr_b;
    logic [7:0] rdata_a;
    logic [7:0] rdata_b;
    logic       rvalid_a;
    logic       rvalid_b;

    logic [7:0] model [6];
    logic [7:0] zexp;
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_2r1w #(.WIDTH(8), .DEPTH(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .re_a     (re_a),
        .raddr_a  (raddr_a),
        .re_b     (re_b),
        .raddr_b  (raddr_b),
        .rdata_a  (rdata_a),
        .rdata_b  (rdata_b),
        .rvalid_a (rvalid_a),
        .rvalid_b (rvalid_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: apply inputs, take the edge, sample 1ns later, then idle the inputs.
    task automatic cyc(input logic w, input logic [2:0] wa, input logic [7:0] wd,
                       input logic ea, input logic [2:0] aa,
                       input logic eb, input logic [2:0] ab);
        we = w; waddr = wa; wdata = wd;
        re_a = ea; raddr_a = aa; re_b = eb; raddr_b = ab;
        @(posedge clk);
        #1;
        if (w && wa < 3'd6 && !(ZERO_EN && wa == 3'd0)) model[wa] = wd;
        we = 1'b0; re_a = 1'b0; re_b = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 6; i++) model[i] = 8'h00;
        rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        re_a = 1'b0; raddr_a = '0; re_b = 1'b0; raddr_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdata_a", 32'(rdata_a), 32'h00);
        check("rst_rdata_b", 32'(rdata_b), 32'h00);
        check("rst_rvalid_a", 32'(rvalid_a), 32'h0);
        check("rst_rvalid_b", 32'(rvalid_b), 32'h0);
        rst_n = 1'b1;

        // Basic write then read
        cyc(1, 3'd5, 8'h3C, 0, 3'd0, 0, 3'd0);
        cyc(0, 3'd0, 8'h00, 1, 3'd5, 0, 3'd0);
        check("basic_rdata_a", 32'(rdata_a), 32'h3C);
        check("basic_rvalid_a", 32'(rvalid_a), 32'h1);
        check("basic_rvalid_b", 32'(rvalid_b), 32'h0);

        // Hold while disabled, even as the word underneath changes
        for (int k = 0; k < 3; k++) begin
            cyc(1, 3'd5, 8'hFF, 0, 3'd5, 0, 3'd0);
            check("hold_rdata_a", 32'(rdata_a), 32'h3C);
            check("hold_rvalid_a", 32'(rvalid_a), 32'h0);
        end

        // Same-cycle write with both ports reading it
        cyc(1, 3'd2, 8'h77, 1, 3'd2, 1, 3'd2);
        check("byp_rdata_a", 32'(rdata_a), 32'h77);
        check("byp_rdata_b", 32'(rdata_b), 32'h77);
        check("byp_rvalid_a", 32'(rvalid_a), 32'h1);
        check("byp_rvalid_b", 32'(rvalid_b), 32'h1);

        cyc(0, 3'd0, 8'h00, 1, 3'd5, 1, 3'd2);
        check("indep_rdata_a", 32'(rdata_a), 32'hFF);
        check("indep_rdata_b", 32'(rdata_b), 32'h77);

        cyc(1, 3'd1, 8'h12, 0, 3'd0, 0, 3'd0);
        cyc(1, 3'd3, 8'h34, 0, 3'd0, 0, 3'd0);
        cyc(1, 3'd4, 8'h45, 0, 3'd0, 0, 3'd0);
        cyc(1, 3'd0, 8'h09, 0, 3'd0, 0, 3'd0);

        // Out-of-range write dropped, out-of-range reads return 0 with valid
        cyc(1, 3'd7, 8'h11, 1, 3'd7, 1, 3'd6);
        check("oor_rdata_a", 32'(rdata_a), 32'h00);
        check("oor_rdata_b", 32'(rdata_b), 32'h00);
        check("oor_rvalid_a", 32'(rvalid_a), 32'h1);
        check("oor_rvalid_b", 32'(rvalid_b), 32'h1);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 3'd0, 8'h00, 1, 3'(i), 1, 3'(5 - i));
            check("scan_rdata_a", 32'(rdata_a), 32'(model[i]));
            check("scan_rdata_b", 32'(rdata_b), 32'(model[5 - i]));
        end

        // Word 0: ordinary storage, or hardwired zero with the option enabled
        zexp = ZERO_EN ? 8'h00 : 8'h5A;
        cyc(1, 3'd0, 8'h5A, 0, 3'd0, 0, 3'd0);
        cyc(0, 3'd0, 8'h00, 1, 3'd0, 1, 3'd0);
        check("w0_rdata_a", 32'(rdata_a), 32'(zexp));
        check("w0_rdata_b", 32'(rdata_b), 32'(zexp));
        check("w0_rvalid_a", 32'(rvalid_a), 32'h1);
        zexp = ZERO_EN ? 8'h00 : 8'h66;
        cyc(1, 3'd0, 8'h66, 1, 3'd0, 1, 3'd0);
        check("w0_byp_rdata_a", 32'(rdata_a), 32'(zexp));
        check("w0_byp_rdata_b", 32'(rdata_b), 32'(zexp));

        // Reset mid-operation with a write in flight
        cyc(1, 3'd3, 8'hA5, 0, 3'd0, 0, 3'd0);
        cyc(0, 3'd0, 8'h00, 1, 3'd3, 1, 3'd3);
        check("pre_rst_rdata_a", 32'(rdata_a), 32'hA5);
        we = 1'b1; waddr = 3'd4; wdata = 8'h99; re_a = 1'b1; raddr_a = 3'd3;
        #3 rst_n = 1'b0;
        #1;
        check("midrst_rdata_a", 32'(rdata_a), 32'h00);
        check("midrst_rdata_b", 32'(rdata_b), 32'h00);
        check("midrst_rvalid_a", 32'(rvalid_a), 32'h0);
        check("midrst_rvalid_b", 32'(rvalid_b), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1; we = 1'b0; re_a = 1'b0;
        for (int i = 0; i < 6; i++) model[i] = 8'h00;
        cyc(0, 3'd0, 8'h00, 1, 3'd3, 1, 3'd4);
        check("postrst_rdata_a", 32'(rdata_a), 32'h00);
        check("postrst_rdata_b", 32'(rdata_b), 32'h00);
        check("postrst_rvalid_a", 32'(rvalid_a), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
